// File: rtl/regfile_sb.sv
// Integer register file with a load scoreboard: execute write port A, load write-back port B
// with RISC-V load extension, combinational bypass, and per-register pending-load tracking.
module regfile_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRP  = 2,
    localparam int unsigned AW  = $clog2(NREG),
    localparam int unsigned CW  = $clog2(NREG + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NRP*AW-1:0]     rd_addr_i,
    output logic [NRP*XLEN-1:0]   rd_data_o,
    output logic [NRP-1:0]        rd_busy_o,
    input  logic                  wa_en_i,
    input  logic [AW-1:0]         wa_addr_i,
    input  logic [XLEN-1:0]       wa_data_i,
    input  logic                  wb_en_i,
    input  logic [AW-1:0]         wb_addr_i,
    input  logic [XLEN-1:0]       wb_data_i,
    input  logic [2:0]            wb_funct3_i,
    input  logic                  iss_en_i,
    input  logic [AW-1:0]         iss_addr_i,
    output logic                  iss_ready_o,
    output logic [NREG-1:0]       busy_o,
    output logic [CW-1:0]         pend_cnt_o,
    output logic                  ld_err_o
);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] wb_ext;
    logic            f3_legal;
    logic            wa_wr;
    logic            wb_wr;
    logic            iss_fire;
    logic            cnt_up;
    logic            cnt_dn;
    logic [NREG-1:0] busy_d;

    // Load data extension selected by funct3; 64-bit-only encodings are illegal at XLEN=32.
    always_comb begin
        wb_ext   = wb_data_i;
        f3_legal = 1'b1;
        case (wb_funct3_i)
            3'b000: wb_ext = XLEN'($signed(wb_data_i[7:0]));
            3'b001: wb_ext = XLEN'($signed(wb_data_i[15:0]));
            3'b010: wb_ext = XLEN'($signed(wb_data_i[31:0]));
            3'b011: f3_legal = (XLEN == 64);
            3'b100: wb_ext = XLEN'(wb_data_i[7:0]);
            3'b101: wb_ext = XLEN'(wb_data_i[15:0]);
            3'b110: begin
                wb_ext   = XLEN'(wb_data_i[31:0]);
                f3_legal = (XLEN == 64);
            end
            default: f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        wa_wr       = wa_en_i && (wa_addr_i != '0);
        wb_wr       = wb_en_i && f3_legal && (wb_addr_i != '0);
        iss_ready_o = !(busy_o[iss_addr_i] && !(wb_wr && (wb_addr_i == iss_addr_i)));
        iss_fire    = iss_en_i && iss_ready_o && (iss_addr_i != '0);
    end

    // Scoreboard next state: clear on load write-back, then set on issue so set wins.
    always_comb begin
        busy_d = busy_o;
        if (wb_wr) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        cnt_up = iss_fire && !busy_o[iss_addr_i];
        cnt_dn = wb_wr && busy_o[wb_addr_i] && !(iss_fire && (iss_addr_i == wb_addr_i));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o     <= '0;
            pend_cnt_o <= '0;
            ld_err_o   <= 1'b0;
        end else begin
            busy_o     <= busy_d;
            pend_cnt_o <= pend_cnt_o + CW'(cnt_up) - CW'(cnt_dn);
            ld_err_o   <= wb_en_i && !f3_legal;
        end
    end

    // Port A is applied last so it wins a same-address collision with port B.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb_wr) begin
                regs[wb_addr_i] <= wb_ext;
            end
            if (wa_wr) begin
                regs[wa_addr_i] <= wa_data_i;
            end
        end
    end

    // Read ports with same-cycle bypass of both write ports.
    always_comb begin
        logic [AW-1:0] ra;
        ra        = '0;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NRP; k++) begin
            ra = rd_addr_i[k*AW +: AW];
            if (ra == '0) begin
                rd_data_o[k*XLEN +: XLEN] = '0;
            end else if (wa_wr && (wa_addr_i == ra)) begin
                rd_data_o[k*XLEN +: XLEN] = wa_data_i;
            end else if (wb_wr && (wb_addr_i == ra)) begin
                rd_data_o[k*XLEN +: XLEN] = wb_ext;
            end else begin
                rd_data_o[k*XLEN +: XLEN] = regs[ra];
            end
            rd_busy_o[k] = busy_o[ra] && !(wb_wr && (wb_addr_i == ra));
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: per-cycle vector table with a queue of registered-output expectations,
// plus hand sequences for mid-cycle reset and 64-bit load encodings.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wa_en, wb_en, iss_en, iss_ready, ld_err;
    logic [4:0]  wa_addr, wb_addr, iss_addr;
    logic [31:0] wa_data, wb_data, busy;
    logic [2:0]  wb_f3;
    logic [5:0]  pend;

    regfile_sb #(.XLEN(32), .NREG(32), .NRP(2)) dut (
        .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_funct3_i(wb_f3),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .iss_ready_o(iss_ready),
        .busy_o(busy), .pend_cnt_o(pend), .ld_err_o(ld_err)
    );

    logic [3:0]  rd_addr64;
    logic [63:0] rd_data64, wb_data64;
    logic [0:0]  rd_busy64;
    logic        wb_en64, iss_ready64, ld_err64;
    logic [3:0]  wb_addr64;
    logic [2:0]  wb_f364;
    logic [15:0] busy64;
    logic [4:0]  pend64;

    regfile_sb #(.XLEN(64), .NREG(16), .NRP(1)) dut64 (
        .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr64), .rd_data_o(rd_data64), .rd_busy_o(rd_busy64),
        .wa_en_i(1'b0), .wa_addr_i(4'd0), .wa_data_i(64'd0),
        .wb_en_i(wb_en64), .wb_addr_i(wb_addr64), .wb_data_i(wb_data64), .wb_funct3_i(wb_f364),
        .iss_en_i(1'b0), .iss_addr_i(4'd0), .iss_ready_o(iss_ready64),
        .busy_o(busy64), .pend_cnt_o(pend64), .ld_err_o(ld_err64)
    );

    typedef struct {
        logic        wa_en;
        logic [4:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [2:0]  f3;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_rb0;
        logic        e_ready;
        logic [5:0]  e_pend;
        logic        e_err;
    } vec_t;

    typedef struct {
        int         idx;
        logic [5:0] pend;
        logic       err;
    } post_t;

    vec_t  vecs[22];
    post_t post_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic wae, input logic [4:0] waa, input logic [31:0] wad,
        input logic wbe, input logic [4:0] wba, input logic [31:0] wbd, input logic [2:0] f3,
        input logic ie, input logic [4:0] ia, input logic [4:0] r0, input logic [4:0] r1,
        input logic [31:0] e0, input logic [31:0] e1, input logic eb, input logic er,
        input logic [5:0] ep, input logic ee);
        vec_t v;
        v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
        v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd; v.f3 = f3;
        v.iss_en = ie; v.iss_addr = ia; v.ra0 = r0; v.ra1 = r1;
        v.e_rd0 = e0; v.e_rd1 = e1; v.e_rb0 = eb; v.e_ready = er; v.e_pend = ep; v.e_err = ee;
        return v;
    endfunction

    task automatic idle();
        wa_en = 0; wa_addr = 0; wa_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; wb_f3 = 0;
        iss_en = 0; iss_addr = 0; rd_addr = 0;
        wb_en64 = 0; wb_addr64 = 0; wb_data64 = 0; wb_f364 = 0; rd_addr64 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            waE wa  waD          wbE wb  wbD            f3    iE ia  r0  r1  rd0            rd1            rb ry pend err
        vecs[0]  = mk(0, 0,  0,            1, 5,  32'h0000_0080, 3'b000, 0, 0,  5,  0,  32'hFFFF_FF80, 0,             0, 1, 0, 0);
        vecs[1]  = mk(0, 0,  0,            1, 6,  32'h0000_0080, 3'b100, 0, 0,  6,  5,  32'h0000_0080, 32'hFFFF_FF80, 0, 1, 0, 0);
        vecs[2]  = mk(1, 7,  32'h1234,     0, 0,  0,             3'b000, 0, 0,  7,  0,  32'h0000_1234, 0,             0, 1, 0, 0);
        vecs[3]  = mk(1, 0,  32'hDEAD,     0, 0,  0,             3'b000, 0, 0,  0,  7,  0,             32'h0000_1234, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0,  0,            1, 8,  32'h0000_8001, 3'b001, 0, 0,  8,  6,  32'hFFFF_8001, 32'h0000_0080, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0,  0,            1, 10, 32'hABCD_8001, 3'b101, 0, 0,  10, 8,  32'h0000_8001, 32'hFFFF_8001, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0,  0,            1, 11, 32'h1234_5678, 3'b010, 0, 0,  11, 0,  32'h1234_5678, 0,             0, 1, 0, 0);
        vecs[7]  = mk(1, 12, 32'h1111,     1, 12, 32'h0000_0022, 3'b100, 0, 0,  12, 0,  32'h0000_1111, 0,             0, 1, 0, 0);
        vecs[8]  = mk(0, 0,  0,            0, 0,  0,             3'b000, 0, 0,  12, 11, 32'h0000_1111, 32'h1234_5678, 0, 1, 0, 0);
        vecs[9]  = mk(0, 0,  0,            1, 13, 32'h0000_0055, 3'b111, 0, 0,  13, 5,  0,             32'hFFFF_FF80, 0, 1, 0, 1);
        vecs[10] = mk(0, 0,  0,            0, 0,  0,             3'b000, 0, 0,  13, 0,  0,             0,             0, 1, 0, 0);
        vecs[11] = mk(0, 0,  0,            1, 14, 32'h0000_0077, 3'b011, 0, 0,  14, 0,  0,             0,             0, 1, 0, 1);
        vecs[12] = mk(0, 0,  0,            0, 0,  0,             3'b000, 1, 9,  9,  0,  0,             0,             0, 1, 1, 0);
        vecs[13] = mk(0, 0,  0,            0, 0,  0,             3'b000, 1, 9,  9,  0,  0,             0,             1, 0, 1, 0);
        vecs[14] = mk(0, 0,  0,            1, 9,  32'h0000_0099, 3'b010, 0, 0,  9,  0,  32'h0000_0099, 0,             0, 1, 0, 0);
        vecs[15] = mk(0, 0,  0,            0, 0,  0,             3'b000, 1, 9,  9,  0,  32'h0000_0099, 0,             0, 1, 1, 0);
        vecs[16] = mk(0, 0,  0,            1, 9,  32'h0000_0005, 3'b010, 1, 9,  9,  0,  32'h0000_0005, 0,             0, 1, 1, 0);
        vecs[17] = mk(0, 0,  0,            0, 0,  0,             3'b000, 0, 0,  9,  0,  32'h0000_0005, 0,             1, 1, 1, 0);
        vecs[18] = mk(0, 0,  0,            0, 0,  0,             3'b000, 1, 0,  0,  9,  0,             32'h0000_0005, 0, 1, 1, 0);
        vecs[19] = mk(1, 9,  32'h4242,     0, 0,  0,             3'b000, 0, 0,  9,  0,  32'h0000_4242, 0,             1, 1, 1, 0);
        vecs[20] = mk(0, 0,  0,            0, 0,  0,             3'b000, 0, 0,  9,  0,  32'h0000_4242, 0,             1, 1, 1, 0);
        vecs[21] = mk(0, 0,  0,            1, 9,  32'h0000_0000, 3'b111, 0, 0,  9,  0,  32'h0000_4242, 0,             1, 1, 1, 1);

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset pend", 64'(pend), 64'd0);
        chk("reset ld_err", 64'(ld_err), 64'd0);
        rd_addr = {5'd3, 5'd1};
        #1;
        chk("reset rd_data", rd_data, 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 22; i++) begin
            post_t p;
            wa_en = vecs[i].wa_en; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
            wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
            wb_f3 = vecs[i].f3; iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            #3;
            chk($sformatf("v%0d rd0", i), 64'(rd_data[31:0]), 64'(vecs[i].e_rd0));
            chk($sformatf("v%0d rd1", i), 64'(rd_data[63:32]), 64'(vecs[i].e_rd1));
            chk($sformatf("v%0d rd_busy0", i), 64'(rd_busy[0]), 64'(vecs[i].e_rb0));
            chk($sformatf("v%0d iss_ready", i), 64'(iss_ready), 64'(vecs[i].e_ready));
            p.idx = i; p.pend = vecs[i].e_pend; p.err = vecs[i].e_err;
            post_q.push_back(p);
            step();
            if (post_q.size() == 0) begin
                chk("scoreboard underflow", 64'd1, 64'd0);
            end else begin
                p = post_q.pop_front();
                chk($sformatf("v%0d pend_cnt", p.idx), 64'(pend), 64'(p.pend));
                chk($sformatf("v%0d ld_err", p.idx), 64'(ld_err), 64'(p.err));
            end
        end

        // Three loads pending (x3, x4, x9), then reset asserted between clock edges.
        idle();
        iss_en = 1; iss_addr = 5'd3;
        step();
        iss_addr = 5'd4;
        step();
        idle();
        rd_addr = {5'd7, 5'd9};
        #1;
        chk("pre-reset busy", 64'(busy), 64'h0000_0218);
        chk("pre-reset pend", 64'(pend), 64'd3);
        chk("pre-reset rd1", 64'(rd_data[63:32]), 64'h1234);
        #1;
        rst = 1'b1;
        #1;
        chk("async reset busy", 64'(busy), 64'd0);
        chk("async reset pend", 64'(pend), 64'd0);
        chk("async reset rd_data", rd_data, 64'd0);
        chk("async reset rd_busy", 64'(rd_busy), 64'd0);
        step();
        rst = 1'b0;
        step();
        wb_en = 1; wb_addr = 5'd3; wb_data = 32'hCAFE; wb_f3 = 3'b010; rd_addr = {5'd0, 5'd3};
        #1;
        chk("post-reset wb rd_busy", 64'(rd_busy[0]), 64'd0);
        chk("post-reset wb bypass", 64'(rd_data[31:0]), 64'hCAFE);
        step();
        idle();
        rd_addr = {5'd0, 5'd3};
        #1;
        chk("post-reset wb stored", 64'(rd_data[31:0]), 64'hCAFE);
        chk("post-reset pend", 64'(pend), 64'd0);
        chk("post-reset ld_err", 64'(ld_err), 64'd0);

        // 64-bit encodings: LD, LW, LWU and an illegal funct3.
        wb_en64 = 1; wb_addr64 = 4'd3; wb_data64 = 64'h8000_0000_0000_0001; wb_f364 = 3'b011;
        step();
        wb_en64 = 0; rd_addr64 = 4'd3;
        #1;
        chk("x64 LD stored", rd_data64, 64'h8000_0000_0000_0001);
        chk("x64 LD ld_err", 64'(ld_err64), 64'd0);
        wb_en64 = 1; wb_addr64 = 4'd4; wb_data64 = 64'h0000_0000_8000_0000; wb_f364 = 3'b010;
        rd_addr64 = 4'd4;
        #1;
        chk("x64 LW bypass", rd_data64, 64'hFFFF_FFFF_8000_0000);
        wb_f364 = 3'b110;
        #1;
        chk("x64 LWU bypass", rd_data64, 64'h0000_0000_8000_0000);
        step();
        wb_en64 = 1; wb_addr64 = 4'd6; wb_data64 = 64'h1; wb_f364 = 3'b111; rd_addr64 = 4'd4;
        #1;
        chk("x64 LWU stored", rd_data64, 64'h0000_0000_8000_0000);
        step();
        wb_en64 = 0; rd_addr64 = 4'd6;
        #1;
        chk("x64 illegal ld_err", 64'(ld_err64), 64'd1);
        chk("x64 illegal no write", rd_data64, 64'd0);
        step();
        chk("x64 ld_err pulse end", 64'(ld_err64), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width; legal values 32 or 64.
REQ-002 SHALL have parameter NREG, default 32, meaning number of architectural registers; power of two, 2..64.
REQ-003 SHALL have parameter NRP, default 2, meaning number of read ports, 1..4.
REQ-004 SHALL have derived parameter AW = $clog2(NREG), meaning address width.
REQ-005 SHALL have port clk_i  input  1  meaning sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  input  1  meaning asynchronous, active-high reset.
REQ-007 SHALL have port rd_addr_i  input  NRP*AW  meaning read addresses, port k at bits [k*AW +: AW].
REQ-008 SHALL have port rd_data_o  output  NRP*XLEN  meaning read data, port k at [k*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy_o  output  NRP  meaning addressed register has a pending load.
REQ-010 SHALL have ports wa_en_i (1), wa_addr_i (AW), wa_data_i (XLEN), all inputs, meaning execute write port A, no extension.
REQ-011 SHALL have ports wb_en_i (1), wb_addr_i (AW), wb_data_i (XLEN), wb_funct3_i (3), all inputs, meaning load write-back port B.
REQ-012 SHALL have ports iss_en_i (1), iss_addr_i (AW), inputs, meaning load issued; marks destination pending.
REQ-013 SHALL have port iss_ready_o  output  1  meaning issue accepted this cycle.
REQ-014 SHALL have port busy_o  output  NREG  meaning scoreboard vector.
REQ-015 SHALL have port pend_cnt_o  output  $clog2(NREG+1)  meaning count of set busy bits.
REQ-016 SHALL have port ld_err_o  output  1  meaning registered one-cycle pulse on illegal wb_funct3_i.

Function
REQ-017 SHALL hold register 0 at zero: reads return 0, writes ignored, never busy, issue to 0 accepted with no effect.
REQ-018 SHALL extend port B data by wb_funct3_i: 000 sign-extend bit 7; 001 sign-extend bit 15; 010 LW (XLEN=32 pass-through, XLEN=64 sign-extend bit 31); 100 zero-extend byte; 101 zero-extend half.
REQ-019 SHALL, for XLEN=64 only, accept 011 LD pass-through and 110 LWU zero-extend bit 31.
REQ-020 SHALL treat any other funct3 with wb_en_i=1 as illegal: no register write, busy bit unchanged, ld_err_o=1 next cycle.
REQ-021 SHALL write enabled ports at the rising edge; same-address A and B write in one cycle: A data stored, B's busy-clear still applied.
REQ-022 SHALL bypass combinationally: a read addressing a register written this cycle returns the post-extension write data (A over B when both).
REQ-023 SHALL drive rd_busy_o[k] = busy bit of rd_addr k, forced 0 when port B legally writes that address this cycle.
REQ-024 SHALL drive iss_ready_o = 0 when iss_addr_i is busy and not being cleared by port B this cycle, else 1.
REQ-025 SHALL set busy[iss_addr_i] at the edge when iss_en_i & iss_ready_o; issue ignored otherwise.
REQ-026 SHALL clear busy[wb_addr_i] at the edge on a legal port B write; set wins over clear on the same address in the same cycle.
REQ-027 SHALL keep pend_cnt_o as a register, incremented/decremented with the scoreboard update so it always equals popcount(busy_o) after each edge.
REQ-028 SHALL leave busy state unchanged on port A writes; port A to a busy register writes data and keeps busy set.

Reset
REQ-029 SHALL, while rst_i=1, immediately clear all registers, busy_o, pend_cnt_o and ld_err_o to 0, independent of clk_i.
REQ-030 SHALL discard any pending loads at reset; a port B write arriving after release proceeds normally on a non-busy register.

Verification
REQ-031 SHALL cover: wb LB data 0x0000_0080 to x5 -> x5 reads 0xFFFF_FF80; same with funct3 100 -> 0x0000_0080.
REQ-032 SHALL cover: wa write x7=0x1234 while rd_addr port0=7 same cycle -> rd_data port0=0x1234 that cycle; write to x0 -> reads 0.
REQ-033 SHALL cover: issue x9, issue x9 again next cycle -> iss_ready_o=0, pend_cnt_o=1; wb x9 -> busy cleared, pend_cnt_o=0.
REQ-034 SHALL cover: same cycle wb x9 clears and issue x9 -> iss_ready_o=1, busy[9] stays 1, pend_cnt_o unchanged.
REQ-035 SHALL cover: wb_funct3_i=111 at XLEN=32 -> no write, ld_err_o high exactly one cycle; XLEN=64 LD 0x8000_0000_0000_0001 stored unchanged.
REQ-036 SHALL cover: rst_i asserted mid-cycle with 3 loads pending -> busy_o=0, pend_cnt_o=0, all reads 0 without clock edge.
